// File: rtl/muldiv_pkg.sv
// Shared encodings for the HI/LO multiply/divide sequencer.
package muldiv_pkg;

   localparam int DEF_WIDTH = 32;

   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIX
   } state_t;

endpackage

// File: rtl/seq_div_step.sv
// One restoring-divide iteration: shift rem:quo left, trial-subtract divisor.
module seq_div_step
   import muldiv_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic [WIDTH-1:0] rem_in,
   input  logic [WIDTH-1:0] quo_in,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_out,
   output logic [WIDTH-1:0] quo_out
);

   logic [WIDTH:0]   shifted;
   logic [WIDTH-1:0] diff;
   logic             borrow;

   assign shifted = {rem_in, quo_in[WIDTH-1]};
   assign borrow  = shifted < {1'b0, divisor};
   // Low bits of the difference are exact whenever there is no borrow.
   assign diff    = shifted[WIDTH-1:0] - divisor;

   assign rem_out = borrow ? shifted[WIDTH-1:0] : diff;
   assign quo_out = {quo_in[WIDTH-2:0], ~borrow};

endmodule

// File: rtl/muldiv_hilo_unit.sv
// HI/LO owner: 1-bit-per-cycle shift-add multiply and restoring divide,
// plus MTHI/MTLO writes while idle.
module muldiv_hilo_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] rs_data,
   input  logic [WIDTH-1:0] rt_data,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH);

   state_t             state;
   logic [CW-1:0]      count;
   logic [2*WIDTH-1:0] acc;
   logic [WIDTH-1:0]   opnd;
   logic [WIDTH-1:0]   rs_raw;
   logic               is_div;
   logic               neg_res;
   logic               neg_rem;
   logic               div_zero;

   logic               sgn_op;
   logic               a_neg;
   logic               b_neg;
   logic [WIDTH-1:0]   a_abs;
   logic [WIDTH-1:0]   b_abs;
   logic [WIDTH:0]     msum;
   logic [2*WIDTH-1:0] mul_nxt;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   rem_nxt;
   logic [WIDTH-1:0]   quo_nxt;

   assign sgn_op = ~op[0];
   assign a_neg  = sgn_op & rs_data[WIDTH-1];
   assign b_neg  = sgn_op & rt_data[WIDTH-1];
   assign a_abs  = a_neg ? -rs_data : rs_data;
   assign b_abs  = b_neg ? -rt_data : rt_data;

   // Multiplier sits in the low half; the add carry becomes the new MSB.
   assign msum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
   assign mul_nxt = acc[0] ? {msum, acc[WIDTH-1:1]}
                           : {1'b0, acc[2*WIDTH-1:1]};
   assign prod    = neg_res ? -acc : acc;

   seq_div_step #(.WIDTH(WIDTH)) u_step (
      .rem_in  (acc[2*WIDTH-1:WIDTH]),
      .quo_in  (acc[WIDTH-1:0]),
      .divisor (opnd),
      .rem_out (rem_nxt),
      .quo_out (quo_nxt)
   );

   assign busy = (state != IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         count    <= '0;
         acc      <= '0;
         opnd     <= '0;
         rs_raw   <= '0;
         is_div   <= 1'b0;
         neg_res  <= 1'b0;
         neg_rem  <= 1'b0;
         div_zero <= 1'b0;
         done     <= 1'b0;
         hi       <= '0;
         lo       <= '0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  unique case (1'b1)
                     (op <= OP_DIVU): begin
                        acc      <= {{WIDTH{1'b0}}, a_abs};
                        opnd     <= b_abs;
                        rs_raw   <= rs_data;
                        is_div   <= op[1];
                        neg_res  <= a_neg ^ b_neg;
                        neg_rem  <= a_neg;
                        div_zero <= op[1] & (rt_data == '0);
                        count    <= CW'(WIDTH - 1);
                        state    <= CALC;
                     end
                     (op == OP_MTHI): hi <= rs_data;
                     (op == OP_MTLO): lo <= rs_data;
                     default: ;
                  endcase
               end
            end
            CALC: begin
               acc   <= is_div ? {rem_nxt, quo_nxt} : mul_nxt;
               count <= count - CW'(1);
               if (count == '0) state <= FIX;
            end
            FIX: begin
               if (div_zero) begin
                  hi <= rs_raw;
                  lo <= '1;
               end else if (is_div) begin
                  hi <= neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
                  lo <= neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
               end else begin
                  hi <= prod[2*WIDTH-1:WIDTH];
                  lo <= prod[WIDTH-1:0];
               end
               done  <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
